// File: rtl/gf_multiplier.sv
// gf_multiplier: sequential modular multiplier computing (a*b) mod p.
// It uses MSB-first interleaved double-and-add and performs one bit of b per clock.
// Optional build macro: GF_MUL_EARLY_EXIT_EN. When it is defined, the bit walk starts
// at the most significant set bit of b instead of bit DATA_W-1. The result is the same
// in both builds; only the latency changes.
module gf_multiplier #(
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] GF_a_mul,
    input  logic [DATA_W-1:0] GF_b_mul,
    input  logic [DATA_W-1:0] p,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] GF_prod_mul
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] p_q, p_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_load;
    logic [DATA_W-1:0] dbl;
    logic [DATA_W-1:0] add;
    logic [DATA_W-1:0] iter_acc;

    // Reduce a value below 2*m into [0, m) with a single conditional subtract.
    function automatic logic [DATA_W-1:0] mod_reduce(input logic [DATA_W:0]   x,
                                                     input logic [DATA_W-1:0] m);
        logic [DATA_W:0] mx;
        logic [DATA_W:0] diff;
        mx   = {1'b0, m};
        diff = x - mx;
        if (x >= mx) begin
            return diff[DATA_W-1:0];
        end
        return x[DATA_W-1:0];
    endfunction

`ifdef GF_MUL_EARLY_EXIT_EN
    // Index of the highest set bit; zero when v is zero.
    function automatic logic [CNT_W-1:0] msb_index(input logic [DATA_W-1:0] v);
        logic [CNT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (v[i]) begin
                idx = CNT_W'(i);
            end
        end
        return idx;
    endfunction

    assign cnt_load = msb_index(GF_b_mul);
`else
    assign cnt_load = CNT_W'(DATA_W - 1);
`endif

    // One double-and-add iteration on the current accumulator.
    always_comb begin
        dbl      = mod_reduce({acc_q, 1'b0}, p_q);
        add      = mod_reduce({1'b0, dbl} + {1'b0, a_q}, p_q);
        iter_acc = b_q[cnt_q] ? add : dbl;
    end

    // Next-state logic for the FSM and datapath registers, plus status outputs.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = GF_a_mul;
                    b_d     = GF_b_mul;
                    p_d     = p;
                    acc_d   = '0;
                    cnt_d   = cnt_load;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                acc_d = iter_acc;
                if (cnt_q == '0) begin
                    // The result becomes visible only when the walk completes,
                    // so the output holds its previous value throughout RUN.
                    prod_d  = iter_acc;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign GF_prod_mul = prod_q;

endmodule

// File: tb/tb_gf_multiplier.sv
// Self-checking bench for gf_multiplier.
// It runs a table of vectors through a result scoreboard, then hand-written sequences:
// a start re-pulse while busy, a reset in the middle of RUN, and back-to-back operation
// with start held high.
module tb_gf_multiplier;

    localparam int W = 256;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] p_in;
    logic         busy;
    logic         done;
    logic [W-1:0] prod;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] p;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    gf_multiplier #(.DATA_W(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .GF_a_mul   (a_in),
        .GF_b_mul   (b_in),
        .p          (p_in),
        .busy       (busy),
        .done       (done),
        .GF_prod_mul(prod)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] ref_mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [W-1:0] m);
        logic [2*W-1:0] full;
        logic [2*W-1:0] rem;
        full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        rem  = full % {{W{1'b0}}, m};
        return rem[W-1:0];
    endfunction

    function automatic int exp_iters(input logic [W-1:0] b);
`ifdef GF_MUL_EARLY_EXIT_EN
        int idx;
        idx = 0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) idx = i;
        end
        return idx + 1;
`else
        return W;
`endif
    endfunction

    // Scoreboard: every done pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                check("product", prod, exp_q.pop_front());
            end
        end
    end

    // Drives a one-cycle start, queues the expected result, and confirms busy rises.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] m, input logic [W-1:0] expv);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        p_in  = m;
        start = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", W'(busy), W'(1));
    endtask

    // Waits for done (bounded) and checks the latency, output stability and pulse width.
    task automatic wait_done(input string name, input int exp_lat);
        int           k;
        bit           seen;
        bit           stable;
        logic [W-1:0] held;
        k      = 0;
        seen   = 1'b0;
        stable = 1'b1;
        held   = prod;
        while (!seen && k < 400) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
            else if (prod !== held) stable = 1'b0;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done_within_400", name);
        end else begin
            check({name, "_latency"}, W'(k), W'(exp_lat));
            check({name, "_prod_stable"}, W'(stable), W'(1));
            @(negedge clk);
            check({name, "_done_width"}, W'(done), W'(0));
            check({name, "_busy_idle"}, W'(busy), W'(0));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] P25519;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int base;
        int iters;
        int period;
        int n_ops;
        int exp_dones;
        int exp_lows;
        int lows;
        int run;
        int max_run;
        int dones_win;
        int drain;

        P25519  = (W'(1) << 255) - W'(19);
        reset_n = 1'b0;
        start   = 1'b0;
        a_in    = '0;
        b_in    = '0;
        p_in    = '0;

        repeat (3) @(negedge clk);
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        check("reset_prod", prod, W'(0));
        reset_n = 1'b1;

        ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} % P25519;
        rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} % P25519;

        vecs[0] = '{p: W'(7),  a: W'(3),      b: W'(5),            exp: W'(1)};
        vecs[1] = '{p: P25519, a: P25519 - 1, b: P25519 - 1,       exp: W'(1)};
        vecs[2] = '{p: P25519, a: W'(2),      b: W'(1) << 254,     exp: W'(19)};
        vecs[3] = '{p: P25519, a: W'('h1234), b: W'(0),            exp: W'(0)};
        vecs[4] = '{p: W'(13), a: W'(12),     b: W'(12),           exp: W'(1)};
        vecs[5] = '{p: P25519, a: P25519 - 1, b: W'(2),            exp: P25519 - 2};
        vecs[6] = '{p: W'(11), a: W'(0),      b: W'(10),           exp: W'(0)};
        vecs[7] = '{p: P25519, a: ra,         b: rb,               exp: ref_mulmod(ra, rb, P25519)};

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].exp);
            wait_done($sformatf("vec%0d", i), exp_iters(vecs[i].b));
        end
        check("table_drained", W'(exp_q.size()), W'(0));

        // Start re-pulsed with other operands around iteration 100 must be ignored.
        base = done_cnt;
        start_op(W'(1234567), P25519 - 3, P25519, ref_mulmod(W'(1234567), P25519 - 3, P25519));
        repeat (99) @(negedge clk);
        a_in  = W'(99);
        b_in  = W'(77);
        p_in  = W'(101);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("repulse", exp_iters(P25519 - 3) - 100);
        check("repulse_one_done", W'(done_cnt - base), W'(1));
        repeat (300) @(negedge clk);
        check("repulse_no_extra_done", W'(done_cnt - base), W'(1));
        check("repulse_queue_empty", W'(exp_q.size()), W'(0));

        // Reset asserted mid-RUN aborts the operation at once, with no done pulse.
        base = done_cnt;
        start_op(W'(5), P25519 - 5, P25519, ref_mulmod(W'(5), P25519 - 5, P25519));
        repeat (49) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_busy", W'(busy), W'(0));
        check("midreset_done", W'(done), W'(0));
        check("midreset_prod", prod, W'(0));
        void'(exp_q.pop_back());
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        check("midreset_no_done", W'(done_cnt - base), W'(0));
        start_op(W'(3), W'(5), W'(7), W'(1));
        wait_done("after_reset", exp_iters(W'(5)));

        // Start held high: back-to-back operations separated by one idle cycle.
        iters     = exp_iters(W'(5));
        period    = iters + 2;
        n_ops     = 599 / period + 1;
        exp_dones = 0;
        exp_lows  = 0;
        for (int k = 0; k < n_ops; k++) begin
            if (k * period + iters <= 599) exp_dones++;
            if (k * period + iters + 1 <= 599) exp_lows++;
            exp_q.push_back(W'(1));
        end
        base    = done_cnt;
        lows    = 0;
        run     = 0;
        max_run = 0;
        @(negedge clk);
        a_in  = W'(3);
        b_in  = W'(5);
        p_in  = W'(7);
        start = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (!busy) begin
                lows++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        start     = 1'b0;
        dones_win = done_cnt - base;
        check("b2b_dones_in_window", W'(dones_win), W'(exp_dones));
        check("b2b_idle_cycles", W'(lows), W'(exp_lows));
        check("b2b_idle_run_len", W'(max_run), W'(1));
        drain = 0;
        while (exp_q.size() != 0 && drain < 1000) begin
            @(negedge clk);
            drain++;
        end
        check("b2b_total_dones", W'(done_cnt - base), W'(n_ops));
        check("b2b_queue_empty", W'(exp_q.size()), W'(0));
        repeat (2) @(negedge clk);
        check("b2b_final_idle", W'(busy), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gf_multiplier.md
GF_MULTIPLIER -- requirements
Module: gf_multiplier

Interface
- REQ-001 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
- REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-003 SHALL have port start, input, 1 bit: request a new multiplication.
- REQ-004 SHALL have port GF_a_mul, input, 256 bits: multiplicand a, unsigned, with a < p.
- REQ-005 SHALL have port GF_b_mul, input, 256 bits: multiplier b, unsigned, with b < p.
- REQ-006 SHALL have port p, input, 256 bits: odd prime modulus, with p < 2^255.
- REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
- REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
- REQ-009 SHALL have port GF_prod_mul, output, 256 bits: result (a*b) mod p.

Function
- REQ-010 SHALL implement an FSM with states IDLE, RUN and DONE.
- REQ-011 SHALL, in IDLE with start=1 at a rising edge:
  - capture a, b and p into internal registers;
  - clear the accumulator acc to 0;
  - load the bit index cnt with 255;
  - move to RUN.
- REQ-012 SHALL perform exactly one MSB-first interleaved double-and-add iteration per clk edge in RUN:
  - d = 2*acc mod p, using a 257-bit intermediate; subtract p once if the intermediate is >= p;
  - if b[cnt]=1, then s = d + a mod p, again with a 257-bit intermediate and a single conditional subtract;
  - acc <= s if b[cnt]=1, otherwise acc <= d.
- REQ-013 SHALL, at the edge where cnt=0, go to DONE; otherwise cnt decrements by 1.
- REQ-014 SHALL, in DONE, drive done=1 and GF_prod_mul=acc, and move to IDLE on the next edge.
- REQ-015 SHALL keep done high for exactly one cycle per accepted start.
- REQ-016 SHALL drive busy=1 in RUN and DONE, and busy=0 in IDLE.
- REQ-017 SHALL hold GF_prod_mul at the last result until the next DONE; it SHALL NOT change during RUN.
- REQ-018 SHALL have a fixed latency when the feature in REQ-026 is excluded:
  - start sampled at edge E0;
  - 256 iterations at edges E1..E256;
  - done high between E256 and E257.
- REQ-019 SHALL ignore start while busy=1: captured operands are unchanged and no extra done pulse is produced.
- REQ-020 SHALL accept a start held high across DONE->IDLE in IDLE as a new operation (back-to-back allowed).
- REQ-021 SHALL use only unsigned arithmetic; operands outside the stated ranges produce an unspecified result but SHALL NOT hang the FSM.

Reset
- REQ-022 SHALL, on reset_n=0, immediately force state=IDLE, busy=0, done=0 and GF_prod_mul=0, independent of clk.
- REQ-023 SHALL clear acc, cnt and the captured operands to 0 on reset.
- REQ-024 SHALL abort an operation in progress when reset is asserted mid-RUN, with no done pulse.
- REQ-025 SHALL accept start no earlier than the first rising edge after reset_n returns high.

Configuration
- REQ-026 SHALL use the macro GF_MUL_EARLY_EXIT_EN to select early exit.
  - Defined: on start, cnt loads with the index of the most significant 1 in b, or 0 if b=0. The iteration count is therefore that index + 1, and done occurs index+1 cycles after the start edge, in the following cycle.
  - Undefined: cnt always loads with 255 and the fixed latency of REQ-018 applies.
  - The numeric result SHALL be identical in both builds.

Verification
- REQ-027 p=7, a=3, b=5, start 1 cycle -> GF_prod_mul=1, done pulse of exactly 1 cycle, after 256 iterations with the macro undefined.
- REQ-028 p=2^255-19, a=p-1, b=p-1 -> GF_prod_mul=1; also p=2^255-19, a=2, b=2^254 -> GF_prod_mul=19.
- REQ-029 a=0x1234, b=0, p=2^255-19 -> GF_prod_mul=0, exactly one done pulse; with GF_MUL_EARLY_EXIT_EN defined, done occurs after 1 iteration.
- REQ-030 start re-pulsed with different operands at iteration 100 -> ignored; result matches the first operands; exactly one done.
- REQ-031 reset_n=0 at iteration 50 -> busy, done and GF_prod_mul all 0 immediately; a new start after release gives the correct product.
- REQ-032 start held high for 600 cycles with p=7, a=3, b=5 -> two back-to-back results of 1, one done per operation, with busy low for exactly one cycle between operations.
